writeback_unit: RTL and testbench
=================================

# writeback_unit

Final-stage write-port driver for the register file. Merges single-cycle execute results with variable-latency data-memory load responses onto the one register-file write port (rd / write data / write enable). It holds an in-order queue of outstanding loads, extracts and extends load data, and exports a per-register busy mask that decode uses for load-use interlocks.

## Interface
Parameters:
- DWIDTH, 32, data width
- LQ_DEPTH, 4, maximum outstanding loads (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alu_valid_i  in  1  execute result present
- alu_ready_o  out  1  execute result accepted this cycle
- alu_rd_i  in  5  destination register
- alu_wren_i  in  1  result writes a register
- alu_data_i  in  DWIDTH  result data
- ld_valid_i  in  1  load issued to memory
- ld_ready_o  out  1  load queue can accept
- ld_rd_i  in  5  load destination
- ld_funct3_i  in  3  load type (LB=0, LH=1, LW=2, LBU=4, LHU=5)
- ld_addr_lo_i  in  2  address bits [1:0]
- mem_rsp_valid_i  in  1  memory returns a word for the oldest load
- mem_rsp_data_i  in  DWIDTH  aligned 32-bit word
- rd_o  out  5  register-file write address
- datawb_o  out  DWIDTH  register-file write data
- regwren_o  out  1  register-file write enable
- busy_o  out  32  bit r set while any queued load targets xr
- err_o  out  1  sticky protocol-error flag

## Operation
- Load queue: a FIFO of {rd, funct3, addr_lo}. Push on ld_valid_i && ld_ready_o. Pop on mem_rsp_valid_i with the queue non-empty. ld_ready_o = (count < LQ_DEPTH). A push and a pop can occur in the same cycle. There is no full-bypass: while full, ld_ready_o stays 0 even if a pop occurs.
- busy_o[r] = OR over valid entries of (entry.rd == r), for r ≠ 0. busy_o[0] is always 0. busy_o is a function of registered queue state only.
- Load extraction from the popped head entry:
  - LB/LBU select byte addr_lo. LH/LHU select halfword addr_lo[1].
  - LB/LH sign-extend. LBU/LHU zero-extend. LW passes the word through.
- ALU path: a 1-entry skid register. alu_ready_o = !skid_valid.
- Write-port arbitration, evaluated each cycle, highest priority first:
  1. Memory response (head pop).
  2. Skid entry.
  3. Incoming accepted ALU result.
- If a response and an accepted ALU result coincide, the ALU result goes into the skid. A skid drain and a new ALU result cannot coincide, because alu_ready_o = 0 while the skid is full.
- Results with alu_wren_i = 0 are accepted and consumed without a write. Writes to x0 (from either path) complete normally but drive regwren_o = 0.
- err_o is set, and stays set until rst, on any of:
  - mem_rsp_valid_i while the queue is empty (the response is ignored)
  - an accepted ALU write whose rd has its busy_o bit set (WAW violation; the write still proceeds)
  - LH/LHU with addr_lo[0] = 1, or LW with addr_lo ≠ 0 (data is extracted aligned-down)
  - funct3 ∈ {3, 6, 7} (LW extraction is used)

## Timing
- The write port is registered. rd_o, datawb_o and regwren_o update on the clock edge after the winning event. The register file's same-cycle forwarding covers readers.
- Load latency: response cycle N → regwren_o high in cycle N+1. The busy_o bit clears in N+1, aligned with that write.
- busy_o is set the cycle after the load is issued.
- ALU latency: accepted in cycle N, no conflict → write in N+1. Displaced by a response → write in N+2.
- regwren_o is asserted for exactly one cycle per write. Back-to-back writes on consecutive cycles are allowed.
- Reset values:
  - regwren_o = 0, rd_o = 0, datawb_o = 0
  - busy_o = 0, err_o = 0
  - alu_ready_o = 1, ld_ready_o = 1
- Reset mid-operation flushes the queue and the skid and drops any pending write. The memory system is reset in the same cycle.

## Structure
- Shared package wb_pkg:
  - load-type enum (LB/LH/LW/LBU/LHU)
  - lq_entry_t struct {rd, funct3, addr_lo}
  - extraction function load_extend(word, funct3, addr_lo)
- Sub-module load_queue: a parameterised synchronous FIFO of lq_entry_t. It exposes the head entry, count, every entry's valid bit, and every entry's rd for the busy_o OR-reduction.

## Test plan
- ALU only: alu rd=5, data=0x1234 in cycle 0 → cycle 1 rd_o=5, datawb_o=0x1234, regwren_o=1. alu rd=0 → regwren_o=0.
- Load extract: word 0x8081_F0F1 returned.
  - LB, addr_lo=3 → 0xFFFF_FF80.
  - LBU, addr_lo=0 → 0x0000_00F1.
  - LH, addr_lo=2 → 0xFFFF_8081.
  - LHU, addr_lo=0 → 0x0000_F0F1.
- Collision: response for x7 and ALU x9 in the same cycle → x7 written in N+1, x9 in N+2, alu_ready_o=0 in N+1.
- Queue full: 4 loads issued (x1–x4) → ld_ready_o=0 and busy_o=0x1E. Pop plus push in the same cycle while full is impossible (ready=0). Responses return in order, clearing bits 1, 2, 3, 4 in turn.
- Errors: each of the following sets err_o=1 and holds it until rst:
  - response with an empty queue (no write)
  - ALU write to x3 while a load to x3 is pending
  - LW with addr_lo=1
- Reset: rst asserted with 2 loads queued and the skid full → next cycle all outputs at their reset values, busy_o=0, ld_ready_o=1.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared load types, queue entry layout and load-data extraction
package wb_pkg;

   typedef enum logic [2:0] {
      LD_B  = 3'd0,
      LD_H  = 3'd1,
      LD_W  = 3'd2,
      LD_BU = 3'd4,
      LD_HU = 3'd5
   } load_type_e;

   typedef struct packed {
      logic [4:0] rd;
      logic [2:0] funct3;
      logic [1:0] addr_lo;
   } lq_entry_t;

   // Misaligned halfwords/words are extracted aligned-down; unknown types fall back to LW.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [2:0]  funct3,
                                               input logic [1:0]  addr_lo);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = 8'(word >> {addr_lo, 3'b000});
      h = addr_lo[1] ? word[31:16] : word[15:0];
      case (load_type_e'(funct3))
         LD_B:    r = {{24{b[7]}}, b};
         LD_H:    r = {{16{h[15]}}, h};
         LD_BU:   r = {24'd0, b};
         LD_HU:   r = {16'd0, h};
         default: r = word;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/load_queue.sv
// rtl/load_queue.sv - in-order FIFO of outstanding loads with per-entry visibility
module load_queue
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  lq_entry_t                     push_data,
   input  logic                          pop,
   output lq_entry_t                     head,
   output logic [$clog2(DEPTH):0]        count,
   output logic [DEPTH-1:0]              valid,
   output logic [DEPTH-1:0][4:0]         rds
);

   localparam int AW = $clog2(DEPTH);

   lq_entry_t        mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // Callers never push when full nor pop when empty, so push and pop never hit the same slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         valid  <= '0;
      end else begin
         if (push) begin
            valid[wr_ptr] <= 1'b1;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         if (pop) begin
            valid[rd_ptr] <= 1'b0;
            rd_ptr        <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

   always_comb begin
      rds = '0;
      for (int i = 0; i < DEPTH; i++) rds[i] = mem[i].rd;
   end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - merges ALU results and load responses onto the register-file write port
module writeback_unit
   import wb_pkg::*;
#(
   parameter int DWIDTH   = 32,
   parameter int LQ_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid_i,
   output logic              alu_ready_o,
   input  logic [4:0]        alu_rd_i,
   input  logic              alu_wren_i,
   input  logic [DWIDTH-1:0] alu_data_i,
   input  logic              ld_valid_i,
   output logic              ld_ready_o,
   input  logic [4:0]        ld_rd_i,
   input  logic [2:0]        ld_funct3_i,
   input  logic [1:0]        ld_addr_lo_i,
   input  logic              mem_rsp_valid_i,
   input  logic [DWIDTH-1:0] mem_rsp_data_i,
   output logic [4:0]        rd_o,
   output logic [DWIDTH-1:0] datawb_o,
   output logic              regwren_o,
   output logic [31:0]       busy_o,
   output logic              err_o
);

   localparam int CW = $clog2(LQ_DEPTH) + 1;

   lq_entry_t                 head;
   lq_entry_t                 push_entry;
   logic [CW-1:0]             count;
   logic [LQ_DEPTH-1:0]       valid;
   logic [LQ_DEPTH-1:0][4:0]  rds;
   logic                      push;
   logic                      pop;
   logic                      alu_write;
   logic                      bad_load;
   logic                      skid_valid;
   logic [4:0]                skid_rd;
   logic [DWIDTH-1:0]         skid_data;
   logic [31:0]               busy;

   assign ld_ready_o  = count < CW'(LQ_DEPTH);
   assign push        = ld_valid_i && ld_ready_o;
   assign pop         = mem_rsp_valid_i && (count != '0);
   assign alu_ready_o = !skid_valid;
   // Results that do not write a register are accepted and simply dropped.
   assign alu_write   = alu_valid_i && alu_ready_o && alu_wren_i;
   assign push_entry  = '{rd: ld_rd_i, funct3: ld_funct3_i, addr_lo: ld_addr_lo_i};

   load_queue #(.DEPTH(LQ_DEPTH)) u_lq (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .count     (count),
      .valid     (valid),
      .rds       (rds)
   );

   always_comb begin
      bad_load = 1'b0;
      case (ld_funct3_i)
         3'd1, 3'd5:       bad_load = ld_addr_lo_i[0];
         3'd2:             bad_load = (ld_addr_lo_i != 2'd0);
         3'd3, 3'd6, 3'd7: bad_load = 1'b1;
         default:          bad_load = 1'b0;
      endcase
   end

   always_comb begin
      busy = '0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
         if (valid[i]) busy[rds[i]] = 1'b1;
      end
      busy[0] = 1'b0;
   end

   assign busy_o = busy;

   // Priority: memory response, then skid, then the incoming ALU result.
   always_ff @(posedge clk) begin
      if (rst) begin
         regwren_o  <= 1'b0;
         rd_o       <= '0;
         datawb_o   <= '0;
         skid_valid <= 1'b0;
         skid_rd    <= '0;
         skid_data  <= '0;
         err_o      <= 1'b0;
      end else begin
         regwren_o <= 1'b0;
         if (pop) begin
            rd_o      <= head.rd;
            datawb_o  <= DWIDTH'(load_extend(32'(mem_rsp_data_i), head.funct3, head.addr_lo));
            regwren_o <= (head.rd != 5'd0);
            if (alu_write) begin
               skid_valid <= 1'b1;
               skid_rd    <= alu_rd_i;
               skid_data  <= alu_data_i;
            end
         end else if (skid_valid) begin
            rd_o       <= skid_rd;
            datawb_o   <= skid_data;
            regwren_o  <= (skid_rd != 5'd0);
            skid_valid <= 1'b0;
         end else if (alu_write) begin
            rd_o      <= alu_rd_i;
            datawb_o  <= alu_data_i;
            regwren_o <= (alu_rd_i != 5'd0);
         end
         if ((mem_rsp_valid_i && count == '0) || (alu_write && busy[alu_rd_i]) ||
             (push && bad_load))
            err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed and randomized checks against a transaction-level model
module tb_writeback_unit;

   localparam int LQ = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, alu_wren, ld_valid, rsp_valid;
   logic [4:0]  alu_rd, ld_rd;
   logic [2:0]  ld_f3;
   logic [1:0]  ld_lo;
   logic [31:0] alu_data, rsp_data;

   logic        alu_ready, ld_ready, regwren, err;
   logic [4:0]  rd;
   logic [31:0] datawb, busy;

   int total = 0;
   int passed = 0;

   writeback_unit #(.DWIDTH(32), .LQ_DEPTH(LQ)) dut (
      .clk             (clk),
      .rst             (rst),
      .alu_valid_i     (alu_valid),
      .alu_ready_o     (alu_ready),
      .alu_rd_i        (alu_rd),
      .alu_wren_i      (alu_wren),
      .alu_data_i      (alu_data),
      .ld_valid_i      (ld_valid),
      .ld_ready_o      (ld_ready),
      .ld_rd_i         (ld_rd),
      .ld_funct3_i     (ld_f3),
      .ld_addr_lo_i    (ld_lo),
      .mem_rsp_valid_i (rsp_valid),
      .mem_rsp_data_i  (rsp_data),
      .rd_o            (rd),
      .datawb_o        (datawb),
      .regwren_o       (regwren),
      .busy_o          (busy),
      .err_o           (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rd;
      logic [2:0] f3;
      logic [1:0] lo;
   } ld_t;

   ld_t         lq[$];
   logic        skid_v;
   logic [4:0]  skid_rd;
   logic [31:0] skid_data;
   logic        exp_we, exp_err, exp_alu_ready, exp_ld_ready;
   logic [4:0]  exp_rd;
   logic [31:0] exp_data, exp_busy;

   function automatic logic [31:0] model_busy();
      logic [31:0] b = '0;
      foreach (lq[i]) if (lq[i].rd != 0) b[lq[i].rd] = 1'b1;
      return b;
   endfunction

   function automatic logic [31:0] ref_extract(logic [31:0] word, logic [2:0] f3, logic [1:0] lo);
      byte     sb;
      shortint sh;
      int      bo = 8 * int'(lo);
      int      ho = lo[1] ? 16 : 0;
      sb = word[bo +: 8];
      sh = word[ho +: 16];
      case (f3)
         3'd0:    return int'(sb);
         3'd1:    return int'(sh);
         3'd4:    return {24'd0, word[bo +: 8]};
         3'd5:    return {16'd0, word[ho +: 16]};
         default: return word;
      endcase
   endfunction

   function automatic logic misaligned(logic [2:0] f3, logic [1:0] lo);
      if (f3 == 3'd1 || f3 == 3'd5) return lo[0];
      if (f3 == 3'd2) return lo != 2'd0;
      return f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
   endfunction

   task automatic clear_inputs();
      alu_valid = 0; alu_wren = 0; alu_rd = 0; alu_data = 0;
      ld_valid = 0; ld_rd = 0; ld_f3 = 0; ld_lo = 0;
      rsp_valid = 0; rsp_data = 0;
   endtask

   // Advance one clock: update the model from the applied inputs, then step the DUT.
   task automatic tick();
      logic [31:0] busy_pre = model_busy();
      logic pop, push, acc;
      ld_t e;
      exp_we = 0;
      if (rst) begin
         lq.delete(); skid_v = 0; exp_err = 0; exp_rd = 0; exp_data = 0;
      end else begin
         pop  = rsp_valid && lq.size() != 0;
         push = ld_valid && lq.size() < LQ;
         acc  = alu_valid && !skid_v && alu_wren;
         if (rsp_valid && lq.size() == 0) exp_err = 1;
         if (acc && busy_pre[alu_rd]) exp_err = 1;
         if (push && misaligned(ld_f3, ld_lo)) exp_err = 1;
         if (pop) begin
            e = lq.pop_front();
            exp_rd = e.rd; exp_data = ref_extract(rsp_data, e.f3, e.lo); exp_we = e.rd != 0;
            if (acc) begin skid_v = 1; skid_rd = alu_rd; skid_data = alu_data; end
         end else if (skid_v) begin
            exp_rd = skid_rd; exp_data = skid_data; exp_we = skid_rd != 0; skid_v = 0;
         end else if (acc) begin
            exp_rd = alu_rd; exp_data = alu_data; exp_we = alu_rd != 0;
         end
         if (push) lq.push_back('{rd: ld_rd, f3: ld_f3, lo: ld_lo});
      end
      @(posedge clk); #1;
      exp_busy = model_busy(); exp_alu_ready = !skid_v; exp_ld_ready = lq.size() < LQ;
   endtask

   task automatic do_reset();
      clear_inputs(); rst = 1; tick(); rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (regwren !== 1'b0) $display("FAIL reset_regwren got %h want 0", regwren); else passed++;
      total++; if (rd !== 5'd0) $display("FAIL reset_rd got %h want 0", rd); else passed++;
      total++; if (datawb !== 32'd0) $display("FAIL reset_data got %h want 0", datawb); else passed++;
      total++; if (busy !== 32'd0 || err !== 1'b0) $display("FAIL reset_busy_err got %h/%b want 0/0", busy, err); else passed++;
      total++; if (alu_ready !== 1'b1 || ld_ready !== 1'b1) $display("FAIL reset_ready got %b%b want 11", alu_ready, ld_ready); else passed++;
   endtask

   task automatic test_alu_only();
      do_reset();
      alu_valid = 1; alu_wren = 1; alu_rd = 5; alu_data = 32'h1234; tick(); clear_inputs();
      total++; if (regwren !== 1'b1 || rd !== 5'd5 || datawb !== 32'h1234)
         $display("FAIL alu_write got %b/%0d/%h want 1/5/00001234", regwren, rd, datawb); else passed++;
      alu_valid = 1; alu_wren = 1; alu_rd = 0; alu_data = 32'hdead; tick(); clear_inputs();
      total++; if (regwren !== 1'b0) $display("FAIL alu_x0 got %b want 0", regwren); else passed++;
      alu_valid = 1; alu_wren = 0; alu_rd = 6; tick(); clear_inputs();
      total++; if (regwren !== 1'b0 || alu_ready !== 1'b1) $display("FAIL alu_nowren got %b/%b want 0/1", regwren, alu_ready); else passed++;
   endtask

   task automatic test_load_extract();
      logic [2:0]  f3s[4]  = '{3'd0, 3'd4, 3'd1, 3'd5};
      logic [1:0]  los[4]  = '{2'd3, 2'd0, 2'd2, 2'd0};
      logic [31:0] wants[4] = '{32'hFFFF_FF80, 32'h0000_00F1, 32'hFFFF_8081, 32'h0000_F0F1};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         ld_valid = 1; ld_rd = 10; ld_f3 = f3s[i]; ld_lo = los[i]; tick(); clear_inputs();
         total++; if (busy !== 32'h400) $display("FAIL extract_busy%0d got %h want 00000400", i, busy); else passed++;
         rsp_valid = 1; rsp_data = 32'h8081_F0F1; tick(); clear_inputs();
         total++; if (regwren !== 1'b1 || rd !== 5'd10 || datawb !== wants[i] || busy !== 32'd0)
            $display("FAIL extract%0d got %b/%0d/%h/%h want 1/10/%h/0", i, regwren, rd, datawb, busy, wants[i]); else passed++;
      end
      total++; if (err !== 1'b0) $display("FAIL extract_err got %b want 0", err); else passed++;
   endtask

   task automatic test_collision();
      logic [31:0] a = $urandom;
      do_reset();
      ld_valid = 1; ld_rd = 7; ld_f3 = 2; tick(); clear_inputs();
      rsp_valid = 1; rsp_data = $urandom; alu_valid = 1; alu_wren = 1; alu_rd = 9; alu_data = a;
      tick(); clear_inputs();
      total++; if (regwren !== 1'b1 || rd !== 5'd7 || datawb !== exp_data || alu_ready !== 1'b0)
         $display("FAIL collide_n1 got %b/%0d/%h/%b want 1/7/%h/0", regwren, rd, datawb, alu_ready, exp_data); else passed++;
      tick();
      total++; if (regwren !== 1'b1 || rd !== 5'd9 || datawb !== a || alu_ready !== 1'b1)
         $display("FAIL collide_n2 got %b/%0d/%h/%b want 1/9/%h/1", regwren, rd, datawb, alu_ready, a); else passed++;
      tick();
      total++; if (regwren !== 1'b0) $display("FAIL collide_one_pulse got %b want 0", regwren); else passed++;
   endtask

   task automatic test_queue_full();
      logic [31:0] want;
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         ld_valid = 1; ld_rd = 5'(i); ld_f3 = 2; tick();
      end
      clear_inputs();
      total++; if (ld_ready !== 1'b0 || busy !== 32'h1E) $display("FAIL full got %b/%h want 0/0000001e", ld_ready, busy); else passed++;
      for (int i = 1; i <= 4; i++) begin
         rsp_valid = 1; rsp_data = $urandom;
         if (i == 1) begin ld_valid = 1; ld_rd = 20; ld_f3 = 2; end
         tick(); clear_inputs();
         want = 32'h1E & ~((32'd1 << (i + 1)) - 1);
         total++; if (regwren !== 1'b1 || rd !== 5'(i) || busy !== want || ld_ready !== 1'b1)
            $display("FAIL drain%0d got %b/%0d/%h/%b want 1/%0d/%h/1", i, regwren, rd, busy, ld_ready, i, want); else passed++;
      end
   endtask

   task automatic test_errors();
      do_reset();
      rsp_valid = 1; rsp_data = 32'h55; tick(); clear_inputs();
      total++; if (err !== 1'b1 || regwren !== 1'b0) $display("FAIL err_empty_rsp got %b/%b want 1/0", err, regwren); else passed++;
      tick(); tick();
      total++; if (err !== 1'b1) $display("FAIL err_sticky got %b want 1", err); else passed++;
      do_reset();
      total++; if (err !== 1'b0) $display("FAIL err_cleared got %b want 0", err); else passed++;
      ld_valid = 1; ld_rd = 3; ld_f3 = 2; tick(); clear_inputs();
      alu_valid = 1; alu_wren = 1; alu_rd = 3; alu_data = 32'h77; tick(); clear_inputs();
      total++; if (err !== 1'b1 || regwren !== 1'b1 || rd !== 5'd3) $display("FAIL err_waw got %b/%b/%0d want 1/1/3", err, regwren, rd); else passed++;
      do_reset();
      ld_valid = 1; ld_rd = 4; ld_f3 = 2; ld_lo = 1; tick(); clear_inputs(); tick();
      total++; if (err !== 1'b1) $display("FAIL err_lw_misaligned got %b want 1", err); else passed++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         ld_valid = 1; ld_rd = 5'(i); ld_f3 = 2; tick();
      end
      clear_inputs();
      rsp_valid = 1; rsp_data = 1; alu_valid = 1; alu_wren = 1; alu_rd = 9; alu_data = 2; tick(); clear_inputs();
      total++; if (alu_ready !== 1'b0 || busy !== 32'h0C) $display("FAIL mid_setup got %b/%h want 0/0000000c", alu_ready, busy); else passed++;
      rst = 1; tick(); rst = 0;
      total++; if (regwren !== 1'b0 || rd !== 5'd0 || datawb !== 32'd0 || busy !== 32'd0 || err !== 1'b0 ||
                   alu_ready !== 1'b1 || ld_ready !== 1'b1)
         $display("FAIL mid_reset got %b/%0d/%h/%h/%b/%b/%b", regwren, rd, datawb, busy, err, alu_ready, ld_ready); else passed++;
      tick();
      total++; if (regwren !== 1'b0) $display("FAIL mid_reset_drop got %b want 0", regwren); else passed++;
   endtask

   task automatic test_random();
      int bad = 0;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rst       = (c % 150 == 149);
         alu_valid = $urandom_range(1, 0); alu_wren = $urandom_range(3, 0) != 0;
         alu_rd    = 5'($urandom_range(7, 0)); alu_data = $urandom;
         ld_valid  = $urandom_range(2, 0) == 0; ld_rd = 5'($urandom_range(7, 0));
         ld_f3     = 3'($urandom); ld_lo = 2'($urandom);
         rsp_valid = $urandom_range(2, 0) == 0; rsp_data = $urandom;
         tick();
         total++;
         if (regwren !== exp_we || (exp_we && (rd !== exp_rd || datawb !== exp_data)) || busy !== exp_busy ||
             err !== exp_err || alu_ready !== exp_alu_ready || ld_ready !== exp_ld_ready) begin
            bad++;
            if (bad <= 5)
               $display("FAIL random_c%0d got we%b rd%0d d%h b%h e%b r%b%b want we%b rd%0d d%h b%h e%b r%b%b",
                        c, regwren, rd, datawb, busy, err, alu_ready, ld_ready,
                        exp_we, exp_rd, exp_data, exp_busy, exp_err, exp_alu_ready, exp_ld_ready);
         end else passed++;
      end
      rst = 0; clear_inputs();
   endtask

   initial begin
      skid_v = 0; skid_rd = 0; skid_data = 0; exp_err = 0;
      test_reset();
      test_alu_only();
      test_load_extract();
      test_collision();
      test_queue_full();
      test_errors();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
